// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and build-time defaults.
// Imported by the receive core, its synchronizer and the interface.
package uart_pkg;

  localparam int DATA_BITS_DEF   = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Bit counter must hold the value DATA_BITS without wrapping.
  function automatic int cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Receive-side bundle: serial line, baud-generator handshake and byte output.
// The slave modport is the receiver core; master is the line/generator/consumer side.
interface uart_rx_core_if #(
  parameter int DATA_BITS = uart_pkg::DATA_BITS_DEF
);

  logic                 rx;
  logic                 clk_baud;
  logic                 baud_enable;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_error;
  logic                 busy;

  modport slave (
    input  rx,
    input  clk_baud,
    output baud_enable,
    output rx_data,
    output rx_valid,
    output frame_error,
    output busy
  );

  modport master (
    output rx,
    output clk_baud,
    input  baud_enable,
    input  rx_data,
    input  rx_valid,
    input  frame_error,
    input  busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx line plus falling-edge
// detect on the synchronized copy.
module uart_rx_sync #(
  parameter int STAGES = uart_pkg::SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              rx_prev;

  // NOTE: flops reset to 1 (line idle level) so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      chain   <= '1;
      rx_prev <= 1'b1;
    end else begin
      chain   <= {chain[STAGES-2:0], rx};
      rx_prev <= chain[STAGES-1];
    end
  end

  assign rx_s = chain[STAGES-1];
  assign fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1-style UART receiver FSM: detects the start edge, runs the baud generator,
// samples on its mid-bit tick and strobes the assembled byte or a framing error.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic          clk,
  input logic          reset,
  uart_rx_core_if.slave bus
);

  localparam int CW = cnt_width(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_rx_core: DATA_BITS must be 5..8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("uart_rx_core: SYNC_STAGES must be at least 2");
  end

  logic rx_s;
  logic fall;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (bus.rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  rx_state_t            state;
  logic [DATA_BITS-1:0] shift;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_error;
  logic                 baud_enable;
  logic                 busy;
  logic                 tick;

  // A tick that arrives while the generator is held off is stale and ignored.
  assign tick = bus.clk_baud & baud_enable;

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch below reads the pre-edge values of the registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      shift       <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      baud_enable <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fall) begin
            state       <= START;
            baud_enable <= 1'b1;
            busy        <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state       <= IDLE;
              baud_enable <= 1'b0;
              busy        <= 1'b0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            // LSB arrives first, so shifting right leaves it in bit 0 at the end.
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == CW'(DATA_BITS - 1)) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_s) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
            state       <= IDLE;
            baud_enable <= 1'b0;
            busy        <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.frame_error = frame_error;
  assign bus.baud_enable = baud_enable;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core (8-bit and 5-bit builds) driven by a
// behavioural receive baud generator with a 16-clock bit period.
`timescale 1ns/1ps
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int BAUD = 16;
  localparam int HALF = BAUD / 2;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  uart_rx_core_if #(.DATA_BITS(8)) bus8 ();
  uart_rx_core_if #(.DATA_BITS(5)) bus5 ();

  uart_rx_core #(.DATA_BITS(8), .SYNC_STAGES(2)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  uart_rx_core #(.DATA_BITS(5), .SYNC_STAGES(2)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5.slave)
  );

  // Receive baud generators: hold half-period preload while disabled.
  logic [4:0] bc8, bc5;
  always @(posedge clk) begin
    if (!reset || !bus8.baud_enable) bc8 <= 5'(HALF - 1);
    else if (bc8 == 5'd0)            bc8 <= 5'(BAUD - 1);
    else                             bc8 <= bc8 - 5'd1;
  end
  always @(posedge clk) begin
    if (!reset || !bus5.baud_enable) bc5 <= 5'(HALF - 1);
    else if (bc5 == 5'd0)            bc5 <= 5'(BAUD - 1);
    else                             bc5 <= bc5 - 5'd1;
  end
  assign bus8.clk_baud = bus8.baud_enable && (bc8 == 5'd0);
  assign bus5.clk_baud = bus5.baud_enable && (bc5 == 5'd0);

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard for the 8-bit receiver.
  exp_t sb[$];
  int   valid_t[$];
  logic tick_d;
  logic prev_strobe = 1'b0;
  always @(posedge clk) tick_d <= bus8.clk_baud;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (prev_strobe)
        check("strobe_width", 32'({bus8.rx_valid, bus8.frame_error}), 32'd0);
      if (bus8.rx_valid || bus8.frame_error) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", 32'({bus8.rx_valid, bus8.frame_error}), 32'd0);
        end else begin
          e = sb.pop_front();
          check("strobe_kind", 32'({bus8.rx_valid, bus8.frame_error}), e.err ? 32'd1 : 32'd2);
          check("rx_data", 32'(bus8.rx_data), 32'(e.data));
          check("busy_at_strobe", 32'(bus8.busy), 32'd0);
          check("enable_at_strobe", 32'(bus8.baud_enable), 32'd0);
          check("tick_before_strobe", 32'(tick_d), 32'd1);
        end
        if (bus8.rx_valid) valid_t.push_back(cyc);
      end
      prev_strobe = bus8.rx_valid | bus8.frame_error;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  // Observation of the 5-bit receiver.
  int         v5_cnt = 0;
  int         fe5_cnt = 0;
  int         v5_t = 0;
  logic [4:0] v5_data = '0;
  always @(negedge clk) begin
    if (reset && bus5.rx_valid) begin
      v5_cnt++;
      v5_t    = cyc;
      v5_data = bus5.rx_data;
    end
    if (reset && bus5.frame_error) fe5_cnt++;
  end

  // Drive one line level for n clocks; caller is always #1 after a posedge.
  task automatic bit_out(input logic five, input logic b, input int n);
    if (five) bus5.rx = b;
    else      bus8.rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic five, input logic [7:0] data, input int nbits,
                            input logic stop);
    bit_out(five, 1'b0, BAUD);
    for (int i = 0; i < nbits; i++) bit_out(five, data[i], BAUD);
    bit_out(five, stop, BAUD);
  endtask

  initial begin
    logic [7:0] held;
    int         t0;
    int         busy_seen;

    bus8.rx = 1'b1;
    bus5.rx = 1'b1;
    reset   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data", 32'(bus8.rx_data), 32'd0);
    check("rst_rx_valid", 32'(bus8.rx_valid), 32'd0);
    check("rst_frame_error", 32'(bus8.frame_error), 32'd0);
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_baud_enable", 32'(bus8.baud_enable), 32'd0);
    reset = 1'b1;
    bit_out(1'b0, 1'b1, 20);

    // Single frame 0xA5.
    held = 8'hA5;
    sb.push_back('{err: 1'b0, data: 8'hA5});
    t0 = cyc;
    send_frame(1'b0, 8'hA5, 8, 1'b1);
    bit_out(1'b0, 1'b1, 20);
    check("a5_consumed", 32'(sb.size()), 32'd0);
    check("a5_valid_count", 32'(valid_t.size()), 32'd1);
    if (valid_t.size() >= 1)
      check("a5_latency", 32'(valid_t[0] - t0 >= 150 && valid_t[0] - t0 <= 160), 32'd1);
    check("a5_held", 32'(bus8.rx_data), 32'(held));

    // Back-to-back 0x3C, 0xFF.
    sb.push_back('{err: 1'b0, data: 8'h3C});
    sb.push_back('{err: 1'b0, data: 8'hFF});
    send_frame(1'b0, 8'h3C, 8, 1'b1);
    send_frame(1'b0, 8'hFF, 8, 1'b1);
    held = 8'hFF;
    bit_out(1'b0, 1'b1, 20);
    check("b2b_consumed", 32'(sb.size()), 32'd0);
    check("b2b_valid_count", 32'(valid_t.size()), 32'd3);
    if (valid_t.size() >= 3)
      check("b2b_gap", 32'(valid_t[2] - valid_t[1]), 32'd160);

    // 5-clock low glitch: false start, no strobe.
    bit_out(1'b0, 1'b0, 5);
    check("glitch_busy", 32'(bus8.busy), 32'd1);
    check("glitch_enable", 32'(bus8.baud_enable), 32'd1);
    bit_out(1'b0, 1'b1, 20);
    check("glitch_idle_busy", 32'(bus8.busy), 32'd0);
    check("glitch_idle_enable", 32'(bus8.baud_enable), 32'd0);
    check("glitch_data_held", 32'(bus8.rx_data), 32'(held));

    // 0x81 with stop bit 0, then break held low for 40 clocks.
    sb.push_back('{err: 1'b1, data: held});
    send_frame(1'b0, 8'h81, 8, 1'b0);
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      bit_out(1'b0, 1'b0, 1);
      if (bus8.busy) busy_seen++;
    end
    check("break_no_retrigger", 32'(busy_seen), 32'd0);
    bit_out(1'b0, 1'b1, 32);
    check("ferr_consumed", 32'(sb.size()), 32'd0);
    check("ferr_data_held", 32'(bus8.rx_data), 32'(held));

    // Reset during data bit 4 of 0x55.
    bit_out(1'b0, 1'b0, BAUD);
    for (int i = 0; i < 4; i++) bit_out(1'b0, 1'(8'h55 >> i), BAUD);
    bit_out(1'b0, 1'b1, 8);
    reset = 1'b0;
    bit_out(1'b0, 1'b1, 2);
    check("mid_rst_rx_data", 32'(bus8.rx_data), 32'd0);
    check("mid_rst_rx_valid", 32'(bus8.rx_valid), 32'd0);
    check("mid_rst_frame_error", 32'(bus8.frame_error), 32'd0);
    check("mid_rst_busy", 32'(bus8.busy), 32'd0);
    check("mid_rst_baud_enable", 32'(bus8.baud_enable), 32'd0);
    reset = 1'b1;
    bit_out(1'b0, 1'b1, 48);
    check("post_rst_idle", 32'(bus8.busy), 32'd0);
    held = 8'h0F;
    sb.push_back('{err: 1'b0, data: 8'h0F});
    send_frame(1'b0, 8'h0F, 8, 1'b1);
    bit_out(1'b0, 1'b1, 20);
    check("post_rst_consumed", 32'(sb.size()), 32'd0);
    check("post_rst_data", 32'(bus8.rx_data), 32'(held));

    // 5-bit build receives 0x13.
    t0 = cyc;
    send_frame(1'b1, 8'h13, 5, 1'b1);
    bit_out(1'b1, 1'b1, 20);
    check("five_valid_count", 32'(v5_cnt), 32'd1);
    check("five_data", 32'(v5_data), 32'h13);
    check("five_ferr_count", 32'(fe5_cnt), 32'd0);
    check("five_latency", 32'(v5_t - t0 >= 96 && v5_t - t0 <= 112), 32'd1);
    check("five_busy_end", 32'(bus5.busy), 32'd0);

    check("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Bit-level UART receiver state machine that sits directly downstream of the receive baud generator. It watches the serial line for a start bit and enables the generator. It then samples each bit on the generator's mid-bit tick and presents the assembled byte with a one-cycle valid strobe. Frame format is fixed 8N1: 1 start bit, DATA_BITS data bits LSB first, no parity, 1 stop bit.

## Interface
- `DATA_BITS`, 8: number of data bits per frame; legal range 5–8.
- `SYNC_STAGES`, 2: depth of the `rx` input synchronizer; minimum 2.
- `clk` in 1: system clock, 50 MHz; single clock domain.
- `reset` in 1: synchronous, active-low reset.
- `rx` in 1: asynchronous serial line; idles high.
- `clk_baud` in 1: one-cycle tick from the receive baud generator, arriving mid-bit.
- `baud_enable` out 1: runs the baud generator; low means the generator holds its half-period preload.
- `rx_data` out DATA_BITS: last correctly framed byte; held until the next valid frame.
- `rx_valid` out 1: one-cycle strobe; `rx_data` is new.
- `frame_error` out 1: one-cycle strobe; the stop bit was sampled as 0.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- `rx` passes through a SYNC_STAGES flop chain, then one extra flop (`rx_prev`) for edge detection.
- States:
  - IDLE: `baud_enable`=0. A falling edge on the synchronized line (`rx_prev`=1, `rx_s`=0) moves to START.
  - START: `baud_enable`=1. On `clk_baud`, if `rx_s`=0 move to DATA and clear the bit counter. If `rx_s`=1 it was a false start: move to IDLE with no strobes.
  - DATA: on each `clk_baud`, shift `rx_s` into the MSB of the shift register (right shift, so LSB-first arrival lands correctly) and increment the bit counter. After the DATA_BITS-th tick, move to STOP.
  - STOP: on `clk_baud`:
    - `rx_s`=1: load `rx_data` from the shift register and pulse `rx_valid`.
    - `rx_s`=0: pulse `frame_error`; `rx_data` is unchanged.
    - Either way, move to IDLE.
- The bit counter is $clog2(DATA_BITS+1) bits wide and never wraps within a frame.
- `clk_baud` is ignored in IDLE.
- Any `clk_baud` seen while `baud_enable`=0 has no effect.
- Line held low after a frame error (break condition): IDLE needs a falling edge, so there is no retrigger until `rx` has returned high for at least one synchronized cycle.
- Falling edge during STOP, before the stop tick: ignored. An edge arriving after the return to IDLE is detected normally, so back-to-back frames are supported.

## Timing
- Reset values:
  - state = IDLE
  - synchronizer flops and `rx_prev` = 1
  - `baud_enable`, `rx_valid`, `frame_error`, `busy` = 0
  - `rx_data` = 0
  - shift register and bit counter = 0
- Edge detection: IDLE→START occurs SYNC_STAGES+1 cycles after `rx` falls at a pin sampled by `clk`.
- `baud_enable` is registered. It rises the cycle after the edge is detected and falls the cycle after the stop tick.
- `rx_valid` and `frame_error` are registered. They go high in the cycle immediately after the stop-bit `clk_baud` and stay high for exactly 1 cycle. They are mutually exclusive.
- Every frame (including false starts) leaves `baud_enable` low for at least 1 cycle. This reloads the generator's half-period preload before the next start bit.
- Reset asserted mid-frame: all state returns to reset values on the next clock edge, with no strobe. Receiving resumes only on a fresh falling edge.

## Structure
- Shared UART package (`uart_pkg`) holds:
  - state encodings: IDLE=0, START=1, DATA=2, STOP=3
  - DATA_BITS default
  - SYNC_STAGES default
- The receive top level instantiates `uart_rx_core` next to the existing receive baud generator. Connections: `baud_enable` → generator enable, generator tick → `clk_baud`.
- One natural sub-module: `uart_rx_sync`, the parameterized synchronizer plus falling-edge detect. Outputs: `rx_s`, `fall`. Flops reset to 1.

## Test plan
Bench instantiates `uart_rx_core` plus the receive baud generator with BAUDRATE=16, so 1 bit = 16 clk.
- Send 0xA5 as 8N1 → `rx_data`=0xA5, with `rx_valid` high for 1 cycle one cycle after the stop tick. `frame_error` stays 0 and `busy` falls on the same cycle.
- Send 0x3C then 0xFF back-to-back (no idle gap) → two `rx_valid` pulses ~160 clk apart, with `rx_data` 0x3C then 0xFF.
- Low glitch of 5 clk on an idle line → START entered, mid-bit sample is 1 → IDLE. No strobes; `baud_enable` drops.
- Send 0x81 with the stop bit forced to 0 → `frame_error` pulses once and `rx_data` keeps its previous value. Holding `rx` low for a further 40 clk causes no new START.
- Assert reset during data bit 4 of 0x55, then release → no strobe, all outputs 0. A following 0x0F frame is received correctly.
- DATA_BITS=5 build, send 0x13 → `rx_data`=5'h13 after 7 bit periods, with `rx_valid` pulsed.
